// File: rtl/alu_exec_stage_pkg.sv
// Shared widths and ALU function codes for the execute stage and its neighbours.
// The ALU decodes sel[4:0] as a function code and sel[SEL_ADDSUB_BIT] as add/sub control.
package alu_exec_stage_pkg;

    localparam int XLEN           = 64;
    localparam int SEL_W          = 7;
    localparam int RD_W           = 5;
    localparam int SEL_ADDSUB_BIT = 5;

    localparam logic [4:0] FN_ADD_SUB = 5'h00;
    localparam logic [4:0] FN_SLL     = 5'h01;
    localparam logic [4:0] FN_SLT     = 5'h02;
    localparam logic [4:0] FN_SLTU    = 5'h03;
    localparam logic [4:0] FN_BLTU    = 5'h04;
    localparam logic [4:0] FN_BLT     = 5'h05;
    localparam logic [4:0] FN_XOR     = 5'h06;
    localparam logic [4:0] FN_SRL     = 5'h07;
    localparam logic [4:0] FN_SRA     = 5'h08;
    localparam logic [4:0] FN_OR      = 5'h09;
    localparam logic [4:0] FN_AND     = 5'h0A;
    localparam logic [4:0] FN_BEQ     = 5'h0C;
    localparam logic [4:0] FN_BNE     = 5'h0D;
    localparam logic [4:0] FN_BGTU    = 5'h0E;
    localparam logic [4:0] FN_BGT     = 5'h0F;

    function automatic logic is_branch_fn(input logic [4:0] fn);
        return (fn == FN_BLTU) || (fn == FN_BLT) || (fn == FN_BEQ) ||
               (fn == FN_BNE)  || (fn == FN_BGTU) || (fn == FN_BGT);
    endfunction

endpackage

// File: rtl/exec_pipe_reg.sv
// Generic pipeline slot: a valid bit plus a payload that only changes on load,
// so downstream logic sees stable values while the slot is empty or stalled.
module exec_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic         drop,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            else if (drop)
                valid <= 1'b0;

            // A flushed slot keeps its old payload to avoid toggling the ALU inputs.
            if (load && !flush)
                q <= d;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage wrapper around the ALU: issue register E drives the ALU, result
// register W captures its output and presents it downstream with branch resolution.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_sladd,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_is_branch,
    input  logic [XLEN-1:0]  in_target,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    output logic [SEL_W-1:0] alu_sel,
    output logic             alu_sladd,
    output logic             alu_select,
    input  logic [XLEN-1:0]  alu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_is_branch,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic             redirect,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int E_W = 3 * XLEN + SEL_W + RD_W + 2;
    localparam int W_W = 2 * XLEN + RD_W + 2;

    logic           e_valid, w_valid;
    logic           w_free, advance, in_fire, out_fire;
    logic [E_W-1:0] e_d, e_q;
    logic [W_W-1:0] w_d, w_q;

    logic [XLEN-1:0] e_op1, e_op2, e_target;
    logic [SEL_W-1:0] e_sel;
    logic [RD_W-1:0] e_rd;
    logic            e_sladd, e_is_branch;

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // valid/payload are held by the sender until then. E moves into W when W is
    // empty or draining this cycle; flush blocks new input and empties both slots.
    assign w_free   = !w_valid || out_ready;
    assign advance  = e_valid && w_free;
    assign in_ready = !flush && (!e_valid || w_free);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign e_d = {in_op1, in_op2, in_sel, in_sladd, in_rd, in_is_branch, in_target};

    exec_pipe_reg #(.W(E_W)) u_stage_e (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .load  (in_fire),
        .drop  (advance),
        .d     (e_d),
        .valid (e_valid),
        .q     (e_q)
    );

    assign {e_op1, e_op2, e_sel, e_sladd, e_rd, e_is_branch, e_target} = e_q;

    assign alu_in1    = e_op1;
    assign alu_in2    = e_op2;
    assign alu_sel    = e_sel;
    assign alu_sladd  = e_sladd;
    assign alu_select = e_valid;

    // Branch compares return their verdict in bit 0; branches write no register value.
    assign w_d = {(e_is_branch ? {XLEN{1'b0}} : alu_out),
                  e_rd, e_is_branch, (e_is_branch & alu_out[0]), e_target};

    exec_pipe_reg #(.W(W_W)) u_stage_w (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .load  (advance),
        .drop  (out_fire),
        .d     (w_d),
        .valid (w_valid),
        .q     (w_q)
    );

    assign out_valid = w_valid;
    assign {out_result, out_rd, out_is_branch, out_taken, out_target} = w_q;

    // A result handed over in the flush cycle still retires; only redirect is killed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect    <= 1'b0;
            retired_cnt <= '0;
        end else begin
            redirect <= !flush && out_fire && out_is_branch && out_taken;
            if (out_fire)
                retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage pipeline wrapper sitting directly upstream and downstream of the 64-bit ALU.
- Accepts decoded operations from the decode stage over a valid/ready handshake and holds them in an issue register that drives the ALU inputs.
- Captures the ALU result one cycle later into a result register and presents it to memory/writeback, together with branch resolution and a redirect pulse.
- Provides two-deep buffering with full backpressure and flush.

Parameters:
XLEN, 64, operand/result width (must match ALU)
SEL_W, 7, ALU operation-select width; bit 5 = add/sub control, bits 4:0 = function code
RD_W, 5, destination register tag width
CNT_W, 32, retired-operation counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  synchronous pipeline kill
in_valid  in  1  decode offers an operation
in_ready  out  1  stage accepts an operation this cycle
in_op1  in  XLEN  source operand 1
in_op2  in  XLEN  source operand 2 / immediate
in_sel  in  SEL_W  ALU select code
in_sladd  in  1  shift-left-1-then-add request
in_rd  in  RD_W  destination tag
in_is_branch  in  1  operation is a conditional branch
in_target  in  XLEN  precomputed branch target
alu_in1  out  XLEN  to ALU
alu_in2  out  XLEN  to ALU
alu_sel  out  SEL_W  to ALU
alu_sladd  out  1  to ALU
alu_select  out  1  ALU enable (power gating of ALU inputs)
alu_out  in  XLEN  combinational result from ALU
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_result  out  XLEN  registered ALU result (0 for branches)
out_rd  out  RD_W  destination tag
out_is_branch  out  1  result belongs to a branch
out_taken  out  1  branch taken (alu_out[0] captured)
out_target  out  XLEN  branch target
redirect  out  1  one-cycle pulse: taken branch leaves stage
retired_cnt  out  CNT_W  count of results accepted downstream

Behaviour:
- Reset (rst_n low, asynchronous):
  - e_valid = w_valid = 0; all payload registers = 0.
  - alu_select = 0, redirect = 0, retired_cnt = 0.
  - Hence in_ready = 1 and out_valid = 0 immediately.
  - Reset mid-operation discards both stages; no partial output.
- Stage E (issue register): holds op1, op2, sel, sladd, rd, is_branch, target.
  - Drives alu_in1/alu_in2/alu_sel/alu_sladd directly from its registers.
  - alu_select = e_valid.
  - While E is empty its registers hold their last values, so ALU inputs do not toggle.
- Stage W (result register) captures alu_out together with the E metadata.
  - out_result = is_branch ? 0 : alu_out.
  - out_taken = is_branch & alu_out[0]; out_taken = 0 for non-branches.
- Handshake signals:
  - w_free = !w_valid | out_ready
  - advance = e_valid & w_free
  - in_ready = !flush & (!e_valid | w_free)
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Per edge when flush = 0:
  - advance: W <= E, w_valid <= 1.
  - else out_fire: w_valid <= 0.
  - in_fire: E <= inputs, e_valid <= 1.
  - else advance: e_valid <= 0.
- Latency and throughput:
  - An op accepted at edge N is out_valid after edge N+1 (2-cycle latency).
  - Full throughput of 1 op/cycle with out_ready held high.
- Backpressure:
  - out_ready = 0 with both stages full: in_ready = 0, and W and E hold stable.
  - Payload outputs stay constant while out_valid = 1 and out_ready = 0.
- Simultaneous in_fire and advance in the same cycle is legal: W takes the old E and E takes the new input.
- Flush:
  - At the edge, e_valid <= 0 and w_valid <= 0; in_ready = 0 during the flush cycle.
  - retired_cnt is unchanged by flush. A result completing out_fire in the same cycle as flush still counts as retired.
- redirect:
  - Registered; asserts for exactly one cycle after an out_fire with out_is_branch & out_taken.
  - Cleared by flush or reset.
- retired_cnt increments by 1 on each out_fire and wraps modulo 2^CNT_W.
- Branch encodings (sel[4:0]):
  - 0x04 BLTU, 0x05 BLT, 0x0C BEQ, 0x0D BNE, 0x0E BGTU, 0x0F BGT.
  - The stage does not decode these; it trusts in_is_branch.

Decomposition:
- Shared package holds:
  - XLEN, SEL_W, RD_W.
  - The 5-bit ALU function-code constants (ADD_SUB through BGT).
  - The sel[5] add/sub bit index.
- One sub-module is natural: exec_pipe_reg, a generic valid/ready payload register with hold, instantiated for stage E and stage W.
- Branch, redirect and counter logic stay in the top level.

Test Plan:
1. Reset: rst_n low mid-stream with both stages full -> out_valid = 0, in_ready = 1, alu_select = 0, retired_cnt = 0 immediately (asynchronous).
2. Single ADD: op1 = 5, op2 = 7, sel = 0x20, out_ready = 1 -> out_valid 2 cycles after accept, out_result = 12, retired_cnt = 1.
3. Back-to-back stream: 8 ops, out_ready = 1 -> in_ready stays 1, 8 consecutive out_valid cycles, results in order, retired_cnt = 8.
4. Backpressure: out_ready = 0 after 2 accepts -> in_ready = 0 and payload stable; release -> both results emerge in order, no loss or duplication.
5. Branch: BEQ with op1 = op2 = 0x55, in_is_branch = 1, target = 0x1000 -> out_taken = 1, out_result = 0, out_target = 0x1000, redirect high exactly 1 cycle after out_fire. BNE with the same operands -> out_taken = 0, no redirect.
6. Flush with both stages full and in_valid = 1 -> in_ready = 0 that cycle, next cycle out_valid = 0 and E empty, retired_cnt unchanged.
